// File: rtl/avg_change_detector.sv
// avg_change_detector: tracks a brightness baseline from the frame-averaging
// stage and raises a valid/ready event once the average has moved at least
// THRESH away from the baseline, in one direction, for CONFIRM consecutive
// updates. Events that arrive while the output slot is still occupied are
// dropped and recorded in a sticky overflow flag.
module avg_change_detector #(
   parameter int THRESH  = 16,   // 1..255
   parameter int CONFIRM = 3     // 1..15
) (
   input  logic       VGA_CLK,
   input  logic       RST_N,
   input  logic [7:0] color,
   input  logic       upd,
   input  logic       evt_ready,
   input  logic       clr_ovf,
   output logic       evt_valid,
   output logic [7:0] evt_color,
   output logic       evt_dir,
   output logic [7:0] baseline,
   output logic       baseline_valid,
   output logic       overflow
);

   typedef enum logic [1:0] {
      S_INIT    = 2'd0,
      S_STABLE  = 2'd1,
      S_PENDING = 2'd2
   } state_t;

   state_t     r_state;
   logic       r_upd_q;
   logic [3:0] r_cnt;
   logic       r_cand_dir;

   logic       w_stb;
   logic [8:0] w_delta;
   logic       w_qualify;
   logic       w_dir;
   logic [3:0] w_cnt_nx;
   logic       w_fire;
   logic       w_slot_free;

   // Any edge of the toggle flag is one new sample.
   assign w_stb = upd ^ r_upd_q;

   // Distance is taken at 9 bits on the larger-minus-smaller side, so it
   // never wraps.
   assign w_delta   = (color >= baseline) ? ({1'b0, color} - {1'b0, baseline})
                                          : ({1'b0, baseline} - {1'b0, color});
   assign w_qualify = (w_delta >= 9'(THRESH));
   assign w_dir     = (color > baseline);
   assign w_cnt_nx  = r_cnt + 4'd1;

   // The confirming sample: either the first qualifier when one suffices,
   // or the one that completes a same-direction run of CONFIRM.
   assign w_fire = w_stb && w_qualify &&
                   (((r_state == S_STABLE) && (CONFIRM == 1)) ||
                    ((r_state == S_PENDING) && (w_dir == r_cand_dir) &&
                     (w_cnt_nx == 4'(CONFIRM))));

   // Slot can take a new event if empty or being drained this very cycle.
   assign w_slot_free = !evt_valid || evt_ready;

   // Sample tracking, baseline/confirm FSM, event slot and overflow flag.
   always_ff @(posedge VGA_CLK) begin
      if (!RST_N) begin
         r_state        <= S_INIT;
         r_upd_q        <= upd;
         r_cnt          <= 4'd0;
         r_cand_dir     <= 1'b0;
         baseline       <= 8'd0;
         baseline_valid <= 1'b0;
         evt_valid      <= 1'b0;
         evt_color      <= 8'd0;
         evt_dir        <= 1'b0;
         overflow       <= 1'b0;
      end else begin
         r_upd_q <= upd;

         if (evt_valid && evt_ready)
            evt_valid <= 1'b0;

         // A drop later in this block overrides the clear.
         if (clr_ovf)
            overflow <= 1'b0;

         if (w_stb) begin
            case (r_state)
               S_INIT: begin
                  baseline       <= color;
                  baseline_valid <= 1'b1;
                  r_state        <= S_STABLE;
               end
               S_STABLE: begin
                  if (w_qualify) begin
                     r_cand_dir <= w_dir;
                     r_cnt      <= 4'd1;
                     if (CONFIRM != 1)
                        r_state <= S_PENDING;
                  end
               end
               S_PENDING: begin
                  if (!w_qualify) begin
                     r_state <= S_STABLE;
                     r_cnt   <= 4'd0;
                  end else if (w_dir != r_cand_dir) begin
                     r_cand_dir <= w_dir;
                     r_cnt      <= 4'd1;
                  end else begin
                     r_cnt <= w_cnt_nx;
                  end
               end
               default: r_state <= S_INIT;
            endcase

            // Confirmed change: rebase on the confirming sample regardless of
            // whether the event itself fits in the slot.
            if (w_fire) begin
               baseline <= color;
               r_cnt    <= 4'd0;
               r_state  <= S_STABLE;
               if (w_slot_free) begin
                  evt_color <= color;
                  evt_dir   <= w_dir;
                  evt_valid <= 1'b1;
               end else begin
                  overflow <= 1'b1;
               end
            end
         end
      end
   end

endmodule
